// File: rtl/eeprom_pkg.sv
// Shared types and constants for the EEPROM read sequencer and its arbiter.
package eeprom_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam int N_REQ = 2;
  // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/eeprom_arbiter_rr_arb2.sv
// Combinational two-input round-robin picker; pri=0 favours input 0 on a tie.
module rr_arb2
  import eeprom_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             pri,
  output logic [N_REQ-1:0] win
);

  // A lone requester wins regardless of pri; pri only breaks ties.
  assign win[0] = req[0] & (~req[1] | ~pri);
  assign win[1] = req[1] & (~req[0] |  pri);

endmodule

// File: rtl/eeprom_arbiter.sv
// Two-client round-robin read sequencer for an asynchronous EEPROM with a fixed
// access time and a one-cycle output-enable recovery gap between reads.
module eeprom_arbiter
  import eeprom_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int WIDTH       = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic [1:0]       REQ,
  input  logic [DEPTH-1:0] REQ_ADDR0,
  input  logic [DEPTH-1:0] REQ_ADDR1,
  output logic [1:0]       GNT,
  output logic [1:0]       DONE,
  output logic [WIDTH-1:0] RDATA,
  output logic [DEPTH-1:0] EE_ADDR,
  output logic             EE_N_OE,
  input  logic [WIDTH-1:0] EE_DATA
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             pri_q, pri_d;
  logic [1:0]       gnt_d, done_d;
  logic [WIDTH-1:0] rdata_d;
  logic [DEPTH-1:0] addr_d;
  logic             n_oe_d;
  logic [1:0]       win;

  rr_arb2 u_rr_arb2 (
    .req (REQ),
    .pri (pri_q),
    .win (win)
  );

  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      pri_q   <= 1'b0;
      GNT     <= '0;
      DONE    <= '0;
      RDATA   <= '0;
      EE_ADDR <= '0;
      EE_N_OE <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      pri_q   <= pri_d;
      GNT     <= gnt_d;
      DONE    <= done_d;
      RDATA   <= rdata_d;
      EE_ADDR <= addr_d;
      EE_N_OE <= n_oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    pri_d   = pri_q;
    gnt_d   = '0;
    done_d  = '0;
    rdata_d = RDATA;
    addr_d  = EE_ADDR;
    n_oe_d  = EE_N_OE;
    unique case (state_q)
      IDLE, RECOVER: begin
        // Arbitration point: REQ is only looked at here, never during ACCESS.
        if (|REQ) begin
          owner_d = win[1];
          addr_d  = win[1] ? REQ_ADDR1 : REQ_ADDR0;
          n_oe_d  = 1'b0;
          cnt_d   = CNT_LOAD;
          gnt_d   = win;
          pri_d   = ~pri_q;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d         = EE_DATA;
          done_d[owner_q] = 1'b1;
          n_oe_d          = 1'b1;
          state_d         = RECOVER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FORMAL
  a_oe_access: assert property (@(posedge CLK) disable iff (!N_RST)
    (EE_N_OE == 1'b0) == (state_q == ACCESS));
  a_onehot: assert property (@(posedge CLK)
    $onehot0(GNT) && $onehot0(DONE) && ((GNT & DONE) == 2'b00));
  a_done_per_gnt: assert property (@(posedge CLK) disable iff (!N_RST)
    (|GNT) |-> ##WAIT_CYCLES (DONE == $past(GNT, WAIT_CYCLES)));
`endif

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed bench for eeprom_arbiter: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=1 instance
// sharing clock, reset and an asynchronous EEPROM model.
module tb_eeprom_arbiter;

  logic       CLK = 1'b0;
  logic       N_RST = 1'b0;
  logic [7:0] mem [4];

  logic [1:0] req = '0, req_w1 = '0;
  logic [1:0] a0 = '0, a1 = '0, a0_w1 = '0, a1_w1 = '0;
  logic [1:0] gnt, done, gnt_w1, done_w1;
  logic [7:0] rdata, rdata_w1, ee_data, ee_data_w1;
  logic [1:0] ee_addr, ee_addr_w1;
  logic       ee_n_oe, ee_n_oe_w1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // Bus floats high when the device is not enabled.
  assign ee_data    = ee_n_oe    ? 8'hFF : mem[ee_addr];
  assign ee_data_w1 = ee_n_oe_w1 ? 8'hFF : mem[ee_addr_w1];

  eeprom_arbiter #(.DEPTH(2), .WIDTH(8), .WAIT_CYCLES(2)) dut (
    .CLK(CLK), .N_RST(N_RST), .REQ(req), .REQ_ADDR0(a0), .REQ_ADDR1(a1),
    .GNT(gnt), .DONE(done), .RDATA(rdata), .EE_ADDR(ee_addr),
    .EE_N_OE(ee_n_oe), .EE_DATA(ee_data)
  );

  eeprom_arbiter #(.DEPTH(2), .WIDTH(8), .WAIT_CYCLES(1)) dut_w1 (
    .CLK(CLK), .N_RST(N_RST), .REQ(req_w1), .REQ_ADDR0(a0_w1), .REQ_ADDR1(a1_w1),
    .GNT(gnt_w1), .DONE(done_w1), .RDATA(rdata_w1), .EE_ADDR(ee_addr_w1),
    .EE_N_OE(ee_n_oe_w1), .EE_DATA(ee_data_w1)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    N_RST = 1'b0; req = '0; req_w1 = '0;
    tick; tick;
    N_RST = 1'b1;
  endtask

  task automatic test_reset;
    N_RST = 1'b0; req = 2'b11; a0 = 2'd1; a1 = 2'd3;
    tick; tick;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", done); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
    checks++; if (ee_addr !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", ee_addr); end
    checks++; if (ee_n_oe !== 1'b1) begin errors++; $display("FAIL reset_n_oe got %b want 1", ee_n_oe); end
    req = '0;
    N_RST = 1'b1;
    tick;
    checks++; if (gnt !== 2'b00 || ee_n_oe !== 1'b1) begin errors++; $display("FAIL idle_no_req gnt %b n_oe %b want 00/1", gnt, ee_n_oe); end
  endtask

  task automatic test_tie;
    a0 = 2'd1; a1 = 2'd3; req = 2'b11;
    tick;
    checks++; if (gnt !== 2'b01 || ee_addr !== 2'd1 || ee_n_oe !== 1'b0) begin errors++; $display("FAIL tie_gnt0 gnt %b addr %0d n_oe %b want 01/1/0", gnt, ee_addr, ee_n_oe); end
    req = 2'b10;
    tick;
    checks++; if (ee_n_oe !== 1'b0 || gnt !== 2'b00 || done !== 2'b00) begin errors++; $display("FAIL tie_access0 n_oe %b gnt %b done %b", ee_n_oe, gnt, done); end
    tick;
    checks++; if (done !== 2'b01 || rdata !== 8'h11 || ee_n_oe !== 1'b1) begin errors++; $display("FAIL tie_done0 done %b rdata %h n_oe %b want 01/11/1", done, rdata, ee_n_oe); end
    tick;
    checks++; if (gnt !== 2'b10 || ee_addr !== 2'd3 || ee_n_oe !== 1'b0) begin errors++; $display("FAIL tie_gnt1 gnt %b addr %0d n_oe %b want 10/3/0", gnt, ee_addr, ee_n_oe); end
    req = 2'b00;
    tick; tick;
    checks++; if (done !== 2'b10 || rdata !== 8'h33) begin errors++; $display("FAIL tie_done1 done %b rdata %h want 10/33", done, rdata); end
    tick;
    checks++; if (done !== 2'b00 || rdata !== 8'h33 || ee_n_oe !== 1'b1) begin errors++; $display("FAIL tie_hold done %b rdata %h n_oe %b", done, rdata, ee_n_oe); end
  endtask

  task automatic test_single;
    a0 = 2'd2; req = 2'b01;
    tick;
    checks++; if (gnt !== 2'b01 || ee_n_oe !== 1'b0 || ee_addr !== 2'd2) begin errors++; $display("FAIL single_gnt gnt %b n_oe %b addr %0d want 01/0/2", gnt, ee_n_oe, ee_addr); end
    req = 2'b00;
    tick;
    checks++; if (ee_n_oe !== 1'b0 || done !== 2'b00) begin errors++; $display("FAIL single_wait n_oe %b done %b want 0/00", ee_n_oe, done); end
    tick;
    checks++; if (done !== 2'b01 || rdata !== 8'hA5 || ee_n_oe !== 1'b1) begin errors++; $display("FAIL single_done done %b rdata %h n_oe %b want 01/a5/1", done, rdata, ee_n_oe); end
    tick;
    checks++; if (done !== 2'b00 || gnt !== 2'b00 || ee_addr !== 2'd2) begin errors++; $display("FAIL single_after done %b gnt %b addr %0d", done, gnt, ee_addr); end
  endtask

  task automatic test_fairness;
    int ngnt = 0, nd0 = 0, nd1 = 0, last = -1, bad_order = 0, bad_gap = 0;
    logic [1:0] exp_g = 2'b01;
    do_reset;
    a0 = 2'd0; a1 = 2'd3; req = 2'b11;
    for (int c = 0; c < 60 && (nd0 + nd1) < 12; c++) begin
      tick;
      if (gnt !== 2'b00) begin
        if (gnt !== exp_g) bad_order++;
        if (last >= 0 && c - last != 3) bad_gap++;
        last = c; exp_g = ~exp_g; ngnt++;
        if (ngnt == 12) req = 2'b00;
      end
      if (done[0]) nd0++;
      if (done[1]) nd1++;
    end
    checks++; if (bad_order != 0) begin errors++; $display("FAIL fair_order bad %0d want 0", bad_order); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL fair_gap bad %0d want 0", bad_gap); end
    checks++; if (ngnt != 12) begin errors++; $display("FAIL fair_grants got %0d want 12", ngnt); end
    checks++; if (nd0 != 6 || nd1 != 6) begin errors++; $display("FAIL fair_dones got %0d/%0d want 6/6", nd0, nd1); end
    tick;
  endtask

  task automatic test_back_to_back;
    int ngnt = 0, nd1 = 0, g0 = 0, last = -1, bad_gap = 0;
    a1 = 2'd1; req = 2'b10;
    for (int c = 0; c < 30; c++) begin
      tick;
      if (gnt[0]) g0++;
      if (gnt[1]) begin
        if (last >= 0 && c - last != 3) bad_gap++;
        last = c; ngnt++;
        if (ngnt == 4) req = 2'b00;
      end
      if (done[1]) begin
        nd1++;
        checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL b2b_rdata got %h want 11", rdata); end
      end
    end
    checks++; if (g0 != 0) begin errors++; $display("FAIL b2b_gnt0 got %0d want 0", g0); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_gap bad %0d want 0", bad_gap); end
    checks++; if (ngnt != 4 || nd1 != 4) begin errors++; $display("FAIL b2b_count gnt %0d done %0d want 4/4", ngnt, nd1); end
  endtask

  task automatic test_reset_mid;
    int stray = 0;
    do_reset;
    a0 = 2'd2; req = 2'b01;
    tick;
    req = 2'b00;
    tick; tick; tick;
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL mid_pre_rdata got %h want a5", rdata); end
    a0 = 2'd1; a1 = 2'd3; req = 2'b11;
    tick;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL mid_gnt got %b want 10", gnt); end
    req = 2'b00;
    tick;
    N_RST = 1'b0;
    tick;
    checks++; if (ee_n_oe !== 1'b1 || gnt !== 2'b00 || done !== 2'b00 || rdata !== 8'h00) begin errors++; $display("FAIL mid_reset n_oe %b gnt %b done %b rdata %h want 1/00/00/00", ee_n_oe, gnt, done, rdata); end
    N_RST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (done !== 2'b00) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", stray); end
    req = 2'b11;
    tick;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_pri got %b want 01", gnt); end
    req = 2'b00;
    tick; tick; tick;
  endtask

  task automatic test_wait1;
    a0_w1 = 2'd0; req_w1 = 2'b01;
    tick;
    checks++; if (gnt_w1 !== 2'b01 || ee_n_oe_w1 !== 1'b0) begin errors++; $display("FAIL w1_gnt gnt %b n_oe %b want 01/0", gnt_w1, ee_n_oe_w1); end
    req_w1 = 2'b00;
    tick;
    checks++; if (done_w1 !== 2'b01 || rdata_w1 !== 8'h5A || ee_n_oe_w1 !== 1'b1) begin errors++; $display("FAIL w1_done done %b rdata %h n_oe %b want 01/5a/1", done_w1, rdata_w1, ee_n_oe_w1); end
    tick;
    checks++; if (done_w1 !== 2'b00 || ee_n_oe_w1 !== 1'b1) begin errors++; $display("FAIL w1_after done %b n_oe %b want 00/1", done_w1, ee_n_oe_w1); end
  endtask

  initial begin
    mem[0] = 8'h5A; mem[1] = 8'h11; mem[2] = 8'hA5; mem[3] = 8'h33;
    test_reset;
    test_tie;
    test_single;
    test_fairness;
    test_back_to_back;
    test_reset_mid;
    test_wait1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
